// File: rtl/lsu_bus_if.sv
// Core-side and memory-side handshake bundles for the load/store unit.
// The core masters lsu_core_if; the LSU masters lsu_mem_if.

interface lsu_core_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [4:0]        req_rd;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic [4:0]        rsp_rd;
    logic [1:0]        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err
    );
endinterface

interface lsu_mem_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [XLEN-1:0]   bus_wdata;
    logic [XLEN/8-1:0] bus_wstrb;
    logic              bus_rvalid;
    logic [XLEN-1:0]   bus_rdata;
    logic              bus_err;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rvalid, bus_rdata, bus_err
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ready, bus_rvalid, bus_rdata, bus_err
    );
endinterface

// File: rtl/lsu_bus.sv
// Load/store unit: turns core accesses into a valid/ready bus transaction with
// lane alignment, load extension, misalignment checks, bus-error and timeout reporting.

module lsu_bus #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    lsu_core_if.slave  core,
    lsu_mem_if.master  mem
);
    localparam int OFS    = $clog2(XLEN / 8);
    localparam int STRB_W = XLEN / 8;
    localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TLIM   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam bit IS64   = (XLEN == 64);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state_q;
    logic              reqReady_q;
    logic              busValid_q;
    logic              rspValid_q;
    logic              busWe_q;
    logic [ADDR_W-1:0] busAddr_q;
    logic [XLEN-1:0]   busWdata_q;
    logic [STRB_W-1:0] busWstrb_q;
    logic [1:0]        rspErr_q;
    logic [XLEN-1:0]   rspRdata_q;
    logic [4:0]        rspRd_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [OFS-1:0]    off_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic [OFS-1:0]    reqOff;
    logic              reqLegal;
    logic              reqAligned;
    logic [STRB_W-1:0] sizeMask;
    logic [XLEN-1:0]   rdShift;
    logic [XLEN-1:0]   loadData;
    logic              timeoutHit;

    assign core.req_ready = reqReady_q;
    assign core.rsp_valid = rspValid_q;
    assign core.rsp_rdata = rspRdata_q;
    assign core.rsp_rd    = rspRd_q;
    assign core.rsp_err   = rspErr_q;
    assign mem.bus_valid  = busValid_q;
    assign mem.bus_we     = busWe_q;
    assign mem.bus_addr   = busAddr_q;
    assign mem.bus_wdata  = busWdata_q;
    assign mem.bus_wstrb  = busWstrb_q;

    assign cnt_d      = cnt_q + CNT_W'(1);
    assign timeoutHit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TLIM));

    // Request decode: legality depends on XLEN, alignment on the access size.
    always_comb begin
        reqOff     = core.req_addr[OFS-1:0];
        reqLegal   = 1'b0;
        reqAligned = 1'b0;
        sizeMask   = '0;
        if (core.req_we) begin
            case (core.req_funct3)
                3'b000, 3'b001, 3'b010: reqLegal = 1'b1;
                3'b011:                 reqLegal = IS64;
                default:                reqLegal = 1'b0;
            endcase
        end else begin
            case (core.req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: reqLegal = 1'b1;
                3'b011, 3'b110:                         reqLegal = IS64;
                default:                                reqLegal = 1'b0;
            endcase
        end
        case (core.req_funct3[1:0])
            2'd0: begin reqAligned = 1'b1;                          sizeMask = STRB_W'(1);  end
            2'd1: begin reqAligned = !core.req_addr[0];             sizeMask = STRB_W'(3);  end
            2'd2: begin reqAligned = (core.req_addr[1:0] == 2'b00); sizeMask = STRB_W'(15); end
            default: begin reqAligned = (core.req_addr[2:0] == 3'b000); sizeMask = '1;      end
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then extend by funct3.
    always_comb begin
        rdShift = mem.bus_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  loadData = XLEN'($signed(rdShift[7:0]));
            3'b001:  loadData = XLEN'($signed(rdShift[15:0]));
            3'b010:  loadData = XLEN'($signed(rdShift[31:0]));
            3'b100:  loadData = XLEN'(rdShift[7:0]);
            3'b101:  loadData = XLEN'(rdShift[15:0]);
            3'b110:  loadData = XLEN'(rdShift[31:0]);
            default: loadData = rdShift;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            reqReady_q <= 1'b1;
            busValid_q <= 1'b0;
            rspValid_q <= 1'b0;
            busWe_q    <= 1'b0;
            busAddr_q  <= '0;
            busWdata_q <= '0;
            busWstrb_q <= '0;
            rspErr_q   <= 2'd0;
            rspRdata_q <= '0;
            rspRd_q    <= 5'd0;
            we_q       <= 1'b0;
            funct3_q   <= 3'd0;
            off_q      <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (core.req_valid) begin
                        we_q       <= core.req_we;
                        funct3_q   <= core.req_funct3;
                        off_q      <= reqOff;
                        rspRd_q    <= core.req_rd;
                        cnt_q      <= '0;
                        busWe_q    <= core.req_we;
                        busAddr_q  <= {core.req_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
                        busWdata_q <= core.req_wdata << {reqOff, 3'b000};
                        busWstrb_q <= core.req_we ? (sizeMask << reqOff) : '0;
                        rspRdata_q <= '0;
                        reqReady_q <= 1'b0;
                        if (reqLegal && reqAligned) begin
                            state_q    <= REQ;
                            busValid_q <= 1'b1;
                        end else begin
                            state_q    <= RESP;
                            rspValid_q <= 1'b1;
                            rspErr_q   <= 2'd1;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_d;
                    if (timeoutHit) begin
                        state_q    <= RESP;
                        busValid_q <= 1'b0;
                        rspValid_q <= 1'b1;
                        rspErr_q   <= 2'd3;
                    end else if (mem.bus_ready) begin
                        state_q    <= WAIT;
                        busValid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    // A response in the timeout cycle still counts as completion.
                    if (mem.bus_rvalid) begin
                        state_q    <= RESP;
                        rspValid_q <= 1'b1;
                        rspErr_q   <= mem.bus_err ? 2'd2 : 2'd0;
                        rspRdata_q <= (!we_q && !mem.bus_err) ? loadData : '0;
                    end else if (timeoutHit) begin
                        state_q    <= RESP;
                        rspValid_q <= 1'b1;
                        rspErr_q   <= 2'd3;
                    end
                end
                RESP: begin
                    if (core.rsp_ready) begin
                        state_q    <= IDLE;
                        rspValid_q <= 1'b0;
                        reqReady_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus: an RV32 instance and an RV64 instance with a short timeout.

module tb_lsu_bus;
    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;

    lsu_core_if #(.XLEN(32), .ADDR_W(32)) c32 ();
    lsu_mem_if  #(.XLEN(32), .ADDR_W(32)) m32 ();
    lsu_core_if #(.XLEN(64), .ADDR_W(32)) c64 ();
    lsu_mem_if  #(.XLEN(64), .ADDR_W(32)) m64 ();

    lsu_bus #(.XLEN(32), .ADDR_W(32), .TIMEOUT(255)) u32 (
        .clk  (clk),
        .rst  (rst),
        .core (c32),
        .mem  (m32)
    );

    lsu_bus #(.XLEN(64), .ADDR_W(32), .TIMEOUT(8)) u64 (
        .clk  (clk),
        .rst  (rst),
        .core (c64),
        .mem  (m64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp)
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            passCount++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus32(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [4:0] rd);
        c32.req_we     = we;
        c32.req_funct3 = f3;
        c32.req_addr   = addr;
        c32.req_wdata  = wdata;
        c32.req_rd     = rd;
        c32.req_valid  = 1'b1;
        step();
        c32.req_valid  = 1'b0;
    endtask

    task automatic applyStimulus64(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [63:0] wdata, input logic [4:0] rd);
        c64.req_we     = we;
        c64.req_funct3 = f3;
        c64.req_addr   = addr;
        c64.req_wdata  = wdata;
        c64.req_rd     = rd;
        c64.req_valid  = 1'b1;
        step();
        c64.req_valid  = 1'b0;
    endtask

    task automatic finishRsp32();
        c32.rsp_ready = 1'b1;
        step();
        c32.rsp_ready = 1'b0;
    endtask

    task automatic finishRsp64();
        c64.rsp_ready = 1'b1;
        step();
        c64.rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst = 1'b1;
        c32.req_valid = 0; c32.req_we = 0; c32.req_funct3 = 0; c32.req_addr = 0;
        c32.req_wdata = 0; c32.req_rd = 0; c32.rsp_ready = 0;
        m32.bus_ready = 0; m32.bus_rvalid = 0; m32.bus_rdata = 0; m32.bus_err = 0;
        c64.req_valid = 0; c64.req_we = 0; c64.req_funct3 = 0; c64.req_addr = 0;
        c64.req_wdata = 0; c64.req_rd = 0; c64.rsp_ready = 0;
        m64.bus_ready = 0; m64.bus_rvalid = 0; m64.bus_rdata = 0; m64.bus_err = 0;

        step();
        step();
        checkOutput("rst.req_ready", c32.req_ready, 1);
        checkOutput("rst.rsp_valid", c32.rsp_valid, 0);
        checkOutput("rst.bus_valid", m32.bus_valid, 0);
        checkOutput("rst.bus_wstrb", m32.bus_wstrb, 0);
        checkOutput("rst.rsp_err",   c32.rsp_err,   0);
        checkOutput("rst.bus_addr",  m32.bus_addr,  0);
        rst = 1'b0;

        // LB with sign extension, zero wait states
        m32.bus_ready = 1; m32.bus_rvalid = 1; m32.bus_rdata = 32'h80FF1234;
        applyStimulus32(1'b0, 3'b000, 32'h80000003, 32'h0, 5'd7);
        checkOutput("lb.bus_valid", m32.bus_valid, 1);
        checkOutput("lb.bus_addr",  m32.bus_addr,  32'h80000000);
        checkOutput("lb.bus_wstrb", m32.bus_wstrb, 0);
        checkOutput("lb.req_ready", c32.req_ready, 0);
        step();
        checkOutput("lb.rsp_valid_e1", c32.rsp_valid, 0);
        step();
        checkOutput("lb.rsp_valid_e2", c32.rsp_valid, 1);
        checkOutput("lb.rdata", c32.rsp_rdata, 32'hFFFFFF80);
        checkOutput("lb.err",   c32.rsp_err,   0);
        checkOutput("lb.rd",    c32.rsp_rd,    7);
        finishRsp32();
        checkOutput("lb.idle_ready", c32.req_ready, 1);

        // SH into both halves of a word
        applyStimulus32(1'b1, 3'b001, 32'h100, 32'h0000BEEF, 5'd3);
        checkOutput("sh0.wdata", m32.bus_wdata, 32'h0000BEEF);
        checkOutput("sh0.wstrb", m32.bus_wstrb, 4'h3);
        checkOutput("sh0.we",    m32.bus_we,    1);
        step(); step();
        checkOutput("sh0.err",   c32.rsp_err,   0);
        checkOutput("sh0.rdata", c32.rsp_rdata, 0);
        finishRsp32();
        applyStimulus32(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 5'd3);
        checkOutput("sh2.wdata", m32.bus_wdata, 32'hBEEF0000);
        checkOutput("sh2.wstrb", m32.bus_wstrb, 4'hC);
        checkOutput("sh2.addr",  m32.bus_addr,  32'h100);
        step(); step();
        checkOutput("sh2.err",   c32.rsp_err,   0);
        checkOutput("sh2.rdata", c32.rsp_rdata, 0);
        finishRsp32();

        // Misaligned LW and SD on RV32 never reach the bus
        applyStimulus32(1'b0, 3'b010, 32'h101, 32'h0, 5'd9);
        checkOutput("lwmis.bus_valid", m32.bus_valid, 0);
        checkOutput("lwmis.rsp_valid", c32.rsp_valid, 1);
        checkOutput("lwmis.err",       c32.rsp_err,   1);
        checkOutput("lwmis.rdata",     c32.rsp_rdata, 0);
        finishRsp32();
        applyStimulus32(1'b1, 3'b011, 32'h200, 32'h1234, 5'd10);
        checkOutput("sd32.bus_valid", m32.bus_valid, 0);
        checkOutput("sd32.err",       c32.rsp_err,   1);
        finishRsp32();

        // Bus error with back-pressure on both sides
        m32.bus_ready = 0; m32.bus_rvalid = 0;
        applyStimulus32(1'b0, 3'b010, 32'h44, 32'h0, 5'd12);
        for (int i = 0; i < 5; i++) begin
            checkOutput("berr.stall_valid", m32.bus_valid, 1);
            checkOutput("berr.stall_addr",  m32.bus_addr,  32'h44);
            step();
        end
        m32.bus_ready = 1;
        step();
        checkOutput("berr.wait_valid", m32.bus_valid, 0);
        step(); step();
        checkOutput("berr.no_rsp_yet", c32.rsp_valid, 0);
        m32.bus_rvalid = 1; m32.bus_err = 1;
        step();
        m32.bus_rvalid = 0; m32.bus_err = 0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("berr.rsp_valid", c32.rsp_valid, 1);
            checkOutput("berr.err",       c32.rsp_err,   2);
            checkOutput("berr.rdata",     c32.rsp_rdata, 0);
            checkOutput("berr.rd",        c32.rsp_rd,    12);
            if (i < 2) step();
        end
        finishRsp32();

        // Timeout with TIMEOUT=8 on the RV64 instance
        m64.bus_ready = 1; m64.bus_rvalid = 0;
        applyStimulus64(1'b0, 3'b011, 32'h1000, 64'h0, 5'd4);
        checkOutput("tmo.bus_valid", m64.bus_valid, 1);
        for (int i = 0; i < 7; i++) step();
        checkOutput("tmo.not_yet", c64.rsp_valid, 0);
        step();
        checkOutput("tmo.rsp_valid", c64.rsp_valid, 1);
        checkOutput("tmo.err",       c64.rsp_err,   3);
        checkOutput("tmo.bus_valid_off", m64.bus_valid, 0);
        finishRsp64();

        // Response on the 8th cycle beats the timeout; LD returns all 64 bits
        m64.bus_rdata = 64'h1122334455667788;
        applyStimulus64(1'b0, 3'b011, 32'h1000, 64'h0, 5'd5);
        for (int i = 0; i < 7; i++) step();
        m64.bus_rvalid = 1;
        step();
        m64.bus_rvalid = 0;
        checkOutput("ld8.rsp_valid", c64.rsp_valid, 1);
        checkOutput("ld8.err",       c64.rsp_err,   0);
        checkOutput("ld8.rdata",     c64.rsp_rdata, 64'h1122334455667788);
        finishRsp64();

        // RV64 upper-word loads and store
        m64.bus_rvalid = 1; m64.bus_rdata = 64'hDEADBEEF_00000000;
        applyStimulus64(1'b0, 3'b110, 32'h2004, 64'h0, 5'd6);
        checkOutput("lwu.addr", m64.bus_addr, 32'h2000);
        step(); step();
        checkOutput("lwu.rdata", c64.rsp_rdata, 64'h00000000DEADBEEF);
        finishRsp64();
        applyStimulus64(1'b0, 3'b010, 32'h2004, 64'h0, 5'd6);
        step(); step();
        checkOutput("lw64.rdata", c64.rsp_rdata, 64'hFFFFFFFFDEADBEEF);
        finishRsp64();
        applyStimulus64(1'b1, 3'b010, 32'h2004, 64'h12345678, 5'd6);
        checkOutput("sw64.wdata", m64.bus_wdata, 64'h12345678_00000000);
        checkOutput("sw64.wstrb", m64.bus_wstrb, 8'hF0);
        step(); step();
        finishRsp64();

        // Asynchronous reset in REQ and in WAIT
        m64.bus_ready = 0; m64.bus_rvalid = 0;
        applyStimulus64(1'b0, 3'b011, 32'h3000, 64'h0, 5'd11);
        checkOutput("rstreq.pre", m64.bus_valid, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstreq.bus_valid", m64.bus_valid, 0);
        checkOutput("rstreq.req_ready", c64.req_ready, 1);
        step();
        rst = 1'b0;
        m64.bus_ready = 1;
        applyStimulus64(1'b1, 3'b011, 32'h3008, 64'hA5A5, 5'd13);
        step();
        checkOutput("rstwait.pre_addr", m64.bus_addr, 32'h3008);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstwait.rsp_valid", c64.rsp_valid, 0);
        checkOutput("rstwait.bus_valid", m64.bus_valid, 0);
        checkOutput("rstwait.req_ready", c64.req_ready, 1);
        checkOutput("rstwait.bus_addr",  m64.bus_addr,  0);
        checkOutput("rstwait.bus_wdata", m64.bus_wdata, 0);
        checkOutput("rstwait.bus_wstrb", m64.bus_wstrb, 0);
        checkOutput("rstwait.rsp_rd",    c64.rsp_rd,    0);
        step();
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
